// File: rtl/set_assoc_cache.sv
// 2-way set-associative, single-word-line cache with per-set LRU, selectable
// write-back or write-through policy and a ready-handshaked memory port.
module set_assoc_cache #(
  parameter int ADDR_SIZE  = 8,
  parameter int DATA_SIZE  = 8,
  parameter int INDEX_SIZE = 2,
  parameter int WRITE_BACK = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 procRead,
  input  logic                 procWrite,
  input  logic [ADDR_SIZE-1:0] procAddress,
  input  logic [DATA_SIZE-1:0] procWData,
  output logic [DATA_SIZE-1:0] procRData,
  output logic                 procReady,
  output logic                 memRead,
  output logic                 memWrite,
  output logic [ADDR_SIZE-1:0] memAddress,
  output logic [DATA_SIZE-1:0] memWData,
  input  logic [DATA_SIZE-1:0] memRData,
  input  logic                 memReady,
  output logic [15:0]          hitCount,
  output logic [15:0]          missCount
);

  localparam int SETS     = 1 << INDEX_SIZE;
  localparam int TAG_SIZE = ADDR_SIZE - INDEX_SIZE;

  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, FILL, MEMWRITE, RESPOND} state_t;

  state_t                   state_q, state_d;
  logic [ADDR_SIZE-1:0]     addr_q, addr_d;
  logic [DATA_SIZE-1:0]     wdata_q, wdata_d;
  logic [DATA_SIZE-1:0]     rdata_q, rdata_d;
  logic                     is_write_q, is_write_d;
  logic                     victim_q, victim_d;
  logic [15:0]              hit_cnt_q, hit_cnt_d;
  logic [15:0]              miss_cnt_q, miss_cnt_d;
  logic [1:0][SETS-1:0]     valid_q, valid_d;
  logic [1:0][SETS-1:0]     dirty_q, dirty_d;
  logic [SETS-1:0]          lru_q, lru_d;
  logic [TAG_SIZE-1:0]      tag_q  [2][SETS];
  logic [TAG_SIZE-1:0]      tag_d  [2][SETS];
  logic [DATA_SIZE-1:0]     data_q [2][SETS];
  logic [DATA_SIZE-1:0]     data_d [2][SETS];

  logic [INDEX_SIZE-1:0]    idx;
  logic [TAG_SIZE-1:0]      req_tag;
  logic                     hit0, hit1, hit_way, pick_way;
  logic                     do_install, inst_way, inst_dirty;
  logic [DATA_SIZE-1:0]     inst_data;

  assign idx      = addr_q[INDEX_SIZE-1:0];
  assign req_tag  = addr_q[ADDR_SIZE-1:INDEX_SIZE];
  assign hit0     = valid_q[0][idx] && (tag_q[0][idx] == req_tag);
  assign hit1     = valid_q[1][idx] && (tag_q[1][idx] == req_tag);
  assign hit_way  = !hit0;
  assign pick_way = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    is_write_d = is_write_q;
    victim_d   = victim_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    lru_d      = lru_q;
    tag_d      = tag_q;
    data_d     = data_q;
    do_install = 1'b0;
    inst_way   = victim_q;
    inst_dirty = 1'b0;
    inst_data  = wdata_q;

    case (state_q)
      IDLE: begin
        if (procWrite || procRead) begin
          addr_d     = procAddress;
          wdata_d    = procWData;
          is_write_d = procWrite;
          state_d    = COMPARE;
        end
      end
      COMPARE: begin
        if (hit0 || hit1) begin
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 16'd1;
          lru_d[idx] = !hit_way;
          if (!is_write_q) begin
            rdata_d = data_q[hit_way][idx];
            state_d = RESPOND;
          end else begin
            data_d[hit_way][idx] = wdata_q;
            if (WRITE_BACK != 0) begin
              dirty_d[hit_way][idx] = 1'b1;
              state_d = RESPOND;
            end else begin
              state_d = MEMWRITE;
            end
          end
        end else begin
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 16'd1;
          victim_d = pick_way;
          if (is_write_q && (WRITE_BACK == 0)) begin
            state_d = MEMWRITE;
          end else if (dirty_q[pick_way][idx]) begin
            state_d = WRITEBACK;
          end else if (is_write_q) begin
            do_install = 1'b1;
            inst_way   = pick_way;
            inst_dirty = 1'b1;
            state_d    = RESPOND;
          end else begin
            state_d = FILL;
          end
        end
      end
      WRITEBACK: begin
        if (memReady) begin
          dirty_d[victim_q][idx] = 1'b0;
          if (is_write_q) begin
            do_install = 1'b1;
            inst_dirty = 1'b1;
            state_d    = RESPOND;
          end else begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (memReady) begin
          do_install = 1'b1;
          inst_data  = memRData;
          rdata_d    = memRData;
          state_d    = RESPOND;
        end
      end
      MEMWRITE: begin
        if (memReady) state_d = RESPOND;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Write-miss allocation and fills share one install path; the way comes
    // from pick_way in COMPARE and from the registered victim afterwards.
    if (do_install) begin
      valid_d[inst_way][idx] = 1'b1;
      dirty_d[inst_way][idx] = inst_dirty;
      tag_d[inst_way][idx]   = req_tag;
      data_d[inst_way][idx]  = inst_data;
      lru_d[idx]             = !inst_way;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      is_write_q <= 1'b0;
      victim_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      lru_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      is_write_q <= is_write_d;
      victim_q   <= victim_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      lru_q      <= lru_d;
    end
  end

  // Tag and data arrays need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  always_comb begin
    memRead    = 1'b0;
    memWrite   = 1'b0;
    memAddress = '0;
    memWData   = '0;
    case (state_q)
      WRITEBACK: begin
        memWrite   = 1'b1;
        memAddress = {tag_q[victim_q][idx], idx};
        memWData   = data_q[victim_q][idx];
      end
      FILL: begin
        memRead    = 1'b1;
        memAddress = addr_q;
      end
      MEMWRITE: begin
        memWrite   = 1'b1;
        memAddress = addr_q;
        memWData   = wdata_q;
      end
      default: ;
    endcase
  end

  assign procReady = (state_q == RESPOND);
  assign procRData = rdata_q;
  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;

endmodule
